// File: rtl/rv_wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// rv_wb_arb_pkg
// Shared types and constants for the rv_wb_arbiter Wishbone master:
//   - arb_state_e : grant FSM states (IDLE, INSTR, DATA)
//   - grant_e     : result of one arbitration decision
//   - WB_SEL_ALL  : byte-select used for instruction fetches
//   - TIMEOUT_CNT_BITS : width of the optional ack-timeout counter
//   - arbitrate() : data-first priority with a fetch anti-starvation override
// -----------------------------------------------------------------------------
package rv_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_INSTR = 2'd1,
        GRANT_DATA  = 2'd2
    } grant_e;

    localparam logic [3:0] WB_SEL_ALL       = 4'hF;
    localparam int         TIMEOUT_CNT_BITS = 16;

    // Data wins a collision unless it has already won streak_full times in a
    // row while a fetch was waiting; then the fetch is let through once.
    function automatic grant_e arbitrate(input logic instr_req,
                                         input logic data_req,
                                         input logic streak_full);
        grant_e grant;
        if (data_req && !(instr_req && streak_full)) begin
            grant = GRANT_DATA;
        end else if (instr_req) begin
            grant = GRANT_INSTR;
        end else begin
            grant = GRANT_NONE;
        end
        return grant;
    endfunction

endpackage

// File: rtl/rv_wb_timeout.sv
// -----------------------------------------------------------------------------
// rv_wb_timeout
// Cycle counter used to abort a Wishbone transfer whose slave never acks.
// Only instantiated when RV_WB_ARBITER_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count from zero (asserted on every grant)
//   enable     : count this cycle (transfer in flight)
//   expire     : count has reached LIMIT while enabled
// -----------------------------------------------------------------------------
module rv_wb_timeout
    import rv_wb_arb_pkg::*;
#(
    parameter int                  CNT_BITS = TIMEOUT_CNT_BITS,
    parameter logic [CNT_BITS-1:0] LIMIT    = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_BITS-1:0] count;

    // Clear has priority so a new grant always starts from zero, even if the
    // previous transfer left the counter mid-way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_BITS'(1);
        end
    end

    assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/rv_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rv_wb_arbiter
// Registered Wishbone-classic master sharing one bus between the core's
// instruction-fetch port and data port. A three-state grant FSM drives
// cyc/stb only while a transfer is in flight; data has priority, but after
// DATA_STREAK_MAX consecutive data grants with a fetch waiting, the fetch wins.
//
// Optional build macro: RV_WB_ARBITER_TIMEOUT_EN
//   Defined   : a transfer not acked within TIMEOUT_CYCLES cycles is aborted;
//               the granted requester's ack and o_bus_err pulse together and
//               read data is forced to zero for that cycle.
//   Undefined : no counter, o_bus_err tied low, the arbiter waits forever.
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_instr_req/addr            fetch request (halfword address)
//   o_instr_ack/data            fetch completion and read data
//   i_data_req/write/addr/wdata/sel   load/store request
//   o_data_ack/rdata            load/store completion and load data
//   o_bus_err                   timeout abort pulse
//   o_wb_* / i_wb_*             Wishbone-classic master interface
// -----------------------------------------------------------------------------
module rv_wb_arbiter
    import rv_wb_arb_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
    parameter int          IADDR_SPACE_BITS = 16,
    parameter int          DATA_STREAK_MAX  = 4,
    parameter int          TIMEOUT_CYCLES   = 255
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_instr_req,
    input  logic [IADDR_SPACE_BITS-1:1]   i_instr_addr,
    output logic                          o_instr_ack,
    output logic [31:0]                   o_instr_data,
    input  logic                          i_data_req,
    input  logic                          i_data_write,
    input  logic [31:0]                   i_data_addr,
    input  logic [31:0]                   i_data_wdata,
    input  logic [3:0]                    i_data_sel,
    output logic                          o_data_ack,
    output logic [31:0]                   o_data_rdata,
    output logic                          o_bus_err,
    output logic [31:0]                   o_wb_adr,
    output logic [31:0]                   o_wb_dat,
    input  logic [31:0]                   i_wb_dat,
    output logic                          o_wb_we,
    output logic [3:0]                    o_wb_sel,
    output logic                          o_wb_stb,
    output logic                          o_wb_cyc,
    input  logic                          i_wb_ack
);

    localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);
    localparam logic [31-IADDR_SPACE_BITS:0] FETCH_BASE = RESET_ADDR[31:IADDR_SPACE_BITS];

    arb_state_e  state_q, state_d;
    grant_e      grant;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [3:0]  streak_q, streak_d;
    logic        instr_ack;
    logic        data_ack;

`ifdef RV_WB_ARBITER_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_BITS-1:0] TIMEOUT_LIMIT = TIMEOUT_CNT_BITS'(TIMEOUT_CYCLES - 1);

    logic timeout_hit;
    logic bus_err;
    logic zero_rdata;

    rv_wb_timeout #(
        .CNT_BITS (TIMEOUT_CNT_BITS),
        .LIMIT    (TIMEOUT_LIMIT)
    ) u_timeout (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .clear  (grant != GRANT_NONE),
        .enable (state_q != IDLE),
        .expire (timeout_hit)
    );
`endif

    // State, streak and every bus output are registered so the Wishbone side
    // never sees combinational paths from the requesters.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            streak_q <= streak_d;
        end
    end

    // Arbitration happens only in IDLE, so every completion is followed by one
    // idle cycle and a request arriving together with an ack waits for it.
    // Bus fields are held untouched during a transfer; an ack seen in IDLE is
    // not addressed to us and is ignored.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        streak_d  = streak_q;
        grant     = GRANT_NONE;
        instr_ack = 1'b0;
        data_ack  = 1'b0;
`ifdef RV_WB_ARBITER_TIMEOUT_EN
        bus_err    = 1'b0;
        zero_rdata = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                grant = arbitrate(i_instr_req, i_data_req, streak_q == STREAK_MAX);
                if (grant == GRANT_DATA) begin
                    state_d = DATA;
                    adr_d   = i_data_addr;
                    dat_d   = i_data_wdata;
                    sel_d   = i_data_sel;
                    we_d    = i_data_write;
                    cyc_d   = 1'b1;
                    // The streak only grows while a fetch is actually waiting.
                    if (!i_instr_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (grant == GRANT_INSTR) begin
                    state_d  = INSTR;
                    adr_d    = {FETCH_BASE, i_instr_addr, 1'b0};
                    sel_d    = WB_SEL_ALL;
                    we_d     = 1'b0;
                    cyc_d    = 1'b1;
                    streak_d = '0;
                end
            end
            INSTR, DATA: begin
                if (i_wb_ack) begin
                    instr_ack = (state_q == INSTR);
                    data_ack  = (state_q == DATA);
                    state_d   = IDLE;
                    cyc_d     = 1'b0;
                end
`ifdef RV_WB_ARBITER_TIMEOUT_EN
                // A real ack in the expiry cycle takes the branch above.
                else if (timeout_hit) begin
                    instr_ack  = (state_q == INSTR);
                    data_ack   = (state_q == DATA);
                    bus_err    = 1'b1;
                    zero_rdata = 1'b1;
                    state_d    = IDLE;
                    cyc_d      = 1'b0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_we     = we_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_instr_ack = instr_ack;
    assign o_data_ack  = data_ack;

    // Read data follows the bus at all times; consumers qualify it with ack.
`ifdef RV_WB_ARBITER_TIMEOUT_EN
    assign o_instr_data = zero_rdata ? 32'h0 : i_wb_dat;
    assign o_data_rdata = zero_rdata ? 32'h0 : i_wb_dat;
    assign o_bus_err    = bus_err;
`else
    assign o_instr_data = i_wb_dat;
    assign o_data_rdata = i_wb_dat;
    assign o_bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv_wb_arbiter
// Self-checking bench for rv_wb_arbiter. Requests are queued per requester;
// each request also pushes its hand-computed completion into a scoreboard
// that a negedge monitor pops whenever the arbiter acks a requester.
// -----------------------------------------------------------------------------
module tb_rv_wb_arbiter;

    typedef struct {
        logic        is_data;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } dreq_t;

    logic        clk;
    logic        rst_n;
    logic        instr_req;
    logic [15:1] instr_addr;
    logic        instr_ack;
    logic [31:0] instr_data;
    logic        data_req;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_sel;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        bus_err;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack;

    logic        slave_ack;
    logic        spur_ack;
    int          slave_wait;
    int          wcnt;
    logic [31:0] slave_data;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    dreq_t       data_q[$];
    logic [14:0] instr_q[$];

    rv_wb_arbiter #(
        .RESET_ADDR       (32'h8000_0000),
        .IADDR_SPACE_BITS (16),
        .DATA_STREAK_MAX  (4),
        .TIMEOUT_CYCLES   (8)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_instr_req  (instr_req),
        .i_instr_addr (instr_addr),
        .o_instr_ack  (instr_ack),
        .o_instr_data (instr_data),
        .i_data_req   (data_req),
        .i_data_write (data_write),
        .i_data_addr  (data_addr),
        .i_data_wdata (data_wdata),
        .i_data_sel   (data_sel),
        .o_data_ack   (data_ack),
        .o_data_rdata (data_rdata),
        .o_bus_err    (bus_err),
        .o_wb_adr     (wb_adr),
        .o_wb_dat     (wb_dat_o),
        .i_wb_dat     (wb_dat_i),
        .o_wb_we      (wb_we),
        .o_wb_sel     (wb_sel),
        .o_wb_stb     (wb_stb),
        .o_wb_cyc     (wb_cyc),
        .i_wb_ack     (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: acks in the slave_wait-th cycle of a transfer (0 = never acks).
    assign wb_ack   = slave_ack | spur_ack;
    assign wb_dat_i = slave_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slave_ack <= 1'b0;
            wcnt      <= 0;
        end else if (slave_ack) begin
            slave_ack <= 1'b0;
            wcnt      <= 0;
        end else if (wb_cyc && slave_wait != 0) begin
            if (wcnt + 1 == slave_wait) slave_ack <= 1'b1;
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit is_data, input bit write,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] sel, input logic [31:0] exp_adr,
                                 input logic [31:0] exp_rdata, input bit exp_err);
        exp_t  e;
        dreq_t d;
        e.is_data = is_data;
        e.adr     = exp_adr;
        e.wdat    = wdata;
        e.sel     = is_data ? sel : 4'hF;
        e.we      = is_data ? write : 1'b0;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        exp_q.push_back(e);
        if (is_data) begin
            d.write = write;
            d.addr  = addr;
            d.wdata = wdata;
            d.sel   = sel;
            data_q.push_back(d);
        end else begin
            instr_q.push_back(addr[14:0]);
        end
    endtask

    task automatic waitDone(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d completions outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Data requester: holds req until its ack, then presents the next entry.
    initial begin
        dreq_t d;
        bit    got;
        bit    aborted;
        data_req   = 1'b0;
        data_write = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        data_sel   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (data_q.size() != 0 && rst_n) begin
                d          = data_q.pop_front();
                data_write = d.write;
                data_addr  = d.addr;
                data_wdata = d.wdata;
                data_sel   = d.sel;
                data_req   = 1'b1;
                got        = 1'b0;
                aborted    = 1'b0;
                for (int n = 0; n < 200 && !got && !aborted; n++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else if (data_ack) got = 1'b1;
                end
                if (!got && !aborted) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL data_ack_wait: no ack after 200 cycles, expected ack");
                end
                if (aborted) data_req = 1'b0;
            end else begin
                data_req = 1'b0;
            end
        end
    end

    // Fetch requester, same handshake as the data side.
    initial begin
        bit got;
        bit aborted;
        instr_req  = 1'b0;
        instr_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (instr_q.size() != 0 && rst_n) begin
                instr_addr = instr_q.pop_front();
                instr_req  = 1'b1;
                got        = 1'b0;
                aborted    = 1'b0;
                for (int n = 0; n < 200 && !got && !aborted; n++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else if (instr_ack) got = 1'b1;
                end
                if (!got && !aborted) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL instr_ack_wait: no ack after 200 cycles, expected ack");
                end
                if (aborted) instr_req = 1'b0;
            end else begin
                instr_req = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every requester ack and checks the bus
    // drops cyc in the following cycle.
    exp_t mon_e;
    bit   ack_seen_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ack_seen_last = 1'b0;
        end else begin
            if (ack_seen_last) checkOutput("cyc_after_ack", 32'(wb_cyc), 32'h0);
            ack_seen_last = 1'b0;
            if (instr_ack || data_ack) begin
                ack_seen_last = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ack: instr_ack=%0b data_ack=%0b, expected no ack",
                             instr_ack, data_ack);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("ack_kind", {30'h0, instr_ack, data_ack},
                                mon_e.is_data ? 32'h1 : 32'h2);
                    checkOutput("wb_adr", wb_adr, mon_e.adr);
                    checkOutput("wb_sel", 32'(wb_sel), 32'(mon_e.sel));
                    checkOutput("wb_we", 32'(wb_we), 32'(mon_e.we));
                    if (mon_e.we) checkOutput("wb_dat", wb_dat_o, mon_e.wdat);
                    checkOutput("rdata", mon_e.is_data ? data_rdata : instr_data, mon_e.rdata);
                    checkOutput("bus_err", 32'(bus_err), 32'(mon_e.err));
                end
            end else if (bus_err) begin
                checks++;
                errors++;
                $display("[TB] FAIL lone_bus_err: bus_err=1 without ack, expected 0");
            end
        end
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        spur_ack   = 1'b0;
        slave_wait = 2;
        slave_data = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_cyc", 32'(wb_cyc), 32'h0);
        checkOutput("rst_stb", 32'(wb_stb), 32'h0);
        checkOutput("rst_adr", wb_adr, 32'h0);
        checkOutput("rst_dat", wb_dat_o, 32'h0);
        checkOutput("rst_sel", 32'(wb_sel), 32'h0);
        checkOutput("rst_we", 32'(wb_we), 32'h0);
        checkOutput("rst_acks", {30'h0, instr_ack, data_ack}, 32'h0);
        checkOutput("rst_err", 32'(bus_err), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fetch alone, two wait states.
        $display("[TB] fetch alone");
        slave_data = 32'hDEAD_BEEF;
        slave_wait = 2;
        applyStimulus(1'b0, 1'b0, 32'h1234, 32'h0, 4'h0, 32'h8000_2468, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        checkOutput("fetch_cyc_before_grant", 32'(wb_cyc), 32'h0);
        @(negedge clk);
        checkOutput("fetch_cyc_granted", 32'(wb_cyc), 32'h1);
        checkOutput("fetch_adr_early", wb_adr, 32'h8000_2468);
        checkOutput("fetch_ack_during_wait", 32'(instr_ack), 32'h0);
        waitDone(50);

        // Collision: store wins, fetch follows after the idle cycle.
        $display("[TB] collision");
        slave_data = 32'h1111_2222;
        slave_wait = 1;
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'h3, 32'h0000_0100, 32'h1111_2222, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0040, 32'h0, 4'h0, 32'h8000_0080, 32'h1111_2222, 1'b0);
        waitDone(50);

        // Starvation: four data grants, one fetch, then data resumes.
        $display("[TB] starvation");
        slave_data = 32'h3C3C_0F0F;
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'h0000_1000, 32'h3C3C_0F0F, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF, 32'h0000_1004, 32'h3C3C_0F0F, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'hF, 32'h0000_1008, 32'h3C3C_0F0F, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_100C, 32'h0, 4'hF, 32'h0000_100C, 32'h3C3C_0F0F, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0800, 32'h0, 4'h0, 32'h8000_1000, 32'h3C3C_0F0F, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'h0000_2000, 32'h3C3C_0F0F, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_2004, 32'h0BAD_F00D, 4'hC, 32'h0000_2004, 32'h3C3C_0F0F, 1'b0);
        waitDone(200);

        // Spurious ack while idle.
        $display("[TB] spurious ack");
        @(posedge clk);
        #1 spur_ack = 1'b1;
        @(negedge clk);
        checkOutput("spurious_acks", {30'h0, instr_ack, data_ack}, 32'h0);
        checkOutput("spurious_err", 32'(bus_err), 32'h0);
        @(posedge clk);
        #1 spur_ack = 1'b0;
        @(negedge clk);
        checkOutput("spurious_cyc", 32'(wb_cyc), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h1, 32'h0000_0300, 32'h3C3C_0F0F, 1'b0);
        waitDone(50);

        // Reset in the middle of a stalled store.
        $display("[TB] reset mid-transfer");
        slave_wait = 0;
        begin
            dreq_t d;
            d.write = 1'b1;
            d.addr  = 32'h0000_0400;
            d.wdata = 32'h1234_5678;
            d.sel   = 4'hF;
            data_q.push_back(d);
        end
        n = 0;
        while (!wb_cyc && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_cyc_up", 32'(wb_cyc), 32'h1);
        repeat (3) @(negedge clk);
        checkOutput("stall_no_err", 32'(bus_err), 32'h0);
        checkOutput("stall_adr", wb_adr, 32'h0000_0400);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_cyc", 32'(wb_cyc), 32'h0);
        checkOutput("midrst_stb", 32'(wb_stb), 32'h0);
        checkOutput("midrst_adr", wb_adr, 32'h0);
        checkOutput("midrst_dat", wb_dat_o, 32'h0);
        checkOutput("midrst_sel_we", {27'h0, wb_sel, wb_we}, 32'h0);
        checkOutput("midrst_acks", {30'h0, instr_ack, data_ack}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        slave_wait = 1;
        repeat (2) @(negedge clk);
        checkOutput("postrst_idle_cyc", 32'(wb_cyc), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h7FFF, 32'h0, 4'h0, 32'h8000_FFFE, 32'h3C3C_0F0F, 1'b0);
        waitDone(50);

`ifdef RV_WB_ARBITER_TIMEOUT_EN
        // Silent slave: abort in the eighth transfer cycle with zeroed data.
        $display("[TB] timeout abort");
        slave_wait = 0;
        slave_data = 32'hCAFE_F00D;
        applyStimulus(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 32'h0000_0500, 32'h0, 1'b1);
        n = 0;
        while (!wb_cyc && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!data_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycle", 32'(n), 32'd7);
        waitDone(50);

        // Ack arriving in the expiry cycle completes normally.
        $display("[TB] ack at timeout boundary");
        slave_wait = 7;
        applyStimulus(1'b1, 1'b0, 32'h0000_0504, 32'h0, 4'hF, 32'h0000_0504, 32'hCAFE_F00D, 1'b0);
        n = 0;
        while (!wb_cyc && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!data_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("late_ack_cycle", 32'(n), 32'd7);
        waitDone(50);
`endif

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at 200000 time units, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rv_wb_arbiter.md
Name: rv_wb_arbiter

Overview:
Registered Wishbone-classic master that shares one bus between the core's instruction-fetch port and data port. It replaces combinational request muxing with an explicit grant FSM. It drives cyc/stb only while a transfer is in flight, applies data-first priority with an anti-starvation limit for fetch, and returns per-requester acks. It sits between rv_core and the system bus.

Parameters:
RESET_ADDR, 32'h0000_0000, supplies fetch address bits [31:IADDR_SPACE_BITS].
IADDR_SPACE_BITS, 16, width of the fetch address space; the port is [IADDR_SPACE_BITS-1:1].
DATA_STREAK_MAX, 4, maximum consecutive data grants while a fetch is pending (range 1..15).
TIMEOUT_CYCLES, 255, cycles without ack before abort (used only with the timeout macro; range 1..65535).

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_instr_req  in  1  fetch request; held until o_instr_ack
i_instr_addr  in  IADDR_SPACE_BITS-1  halfword fetch address
o_instr_ack  out  1  fetch complete; o_instr_data valid this cycle
o_instr_data  out  32  fetch read data
i_data_req  in  1  load/store request; held until o_data_ack
i_data_write  in  1  1 = store
i_data_addr  in  32  byte address
i_data_wdata  in  32  store data
i_data_sel  in  4  byte lanes
o_data_ack  out  1  data transfer complete
o_data_rdata  out  32  load data
o_bus_err  out  1  one-cycle pulse on timeout abort (0 without the macro)
o_wb_adr  out  32  Wishbone address
o_wb_dat  out  32  Wishbone write data
i_wb_dat  in  32  Wishbone read data
o_wb_we  out  1  write enable
o_wb_sel  out  4  byte select
o_wb_stb  out  1  strobe
o_wb_cyc  out  1  cycle
i_wb_ack  in  1  slave ack

Behaviour:
- Reset (async, i_reset_n=0):
  - FSM to IDLE; streak counter 0.
  - All outputs 0, including o_wb_cyc, o_wb_stb, adr, dat, sel and we.
  - Reset mid-transfer drops cyc/stb immediately and generates no ack.
- FSM states: IDLE, INSTR, DATA.
- IDLE arbitration, performed on registered inputs at the clock edge:
  - data only: grant DATA.
  - instr only: grant INSTR.
  - both pending: grant DATA unless streak==DATA_STREAK_MAX, in which case grant INSTR.
- On grant, in the same edge, register the bus outputs:
  - DATA: o_wb_adr=i_data_addr, o_wb_dat=i_data_wdata, o_wb_sel=i_data_sel, o_wb_we=i_data_write.
  - INSTR: o_wb_adr={RESET_ADDR[31:IADDR_SPACE_BITS], i_instr_addr, 1'b0}, o_wb_sel=4'hF, o_wb_we=0, o_wb_dat held.
  - Set cyc=stb=1.
- Latency: request visible in IDLE → cyc/stb high the next cycle. Minimum 2 cycles from request to ack with a zero-wait slave.
- INSTR/DATA states: hold all bus outputs stable until i_wb_ack. On the ack cycle:
  - o_instr_ack or o_data_ack = i_wb_ack, combinational and same cycle.
  - Matching read data = i_wb_dat, combinational.
  - Non-granted ack stays 0.
  - Next state IDLE; cyc/stb drop. This gives one idle cycle between transfers.
- Read-data ports reflect i_wb_dat at all times; they are qualified only by ack.
- Streak counter, updated at each DATA grant:
  - DATA grant with i_instr_req high: streak+1, saturating at DATA_STREAK_MAX.
  - DATA grant with i_instr_req low: streak reset to 0.
  - Any INSTR grant: streak reset to 0.
- i_wb_ack in IDLE (spurious) is ignored; no requester ack is produced.
- Requester deasserting req before its ack is a protocol violation. The transfer completes anyway and the ack is still pulsed.
- Simultaneous new request and ack: the new request is arbitrated in the following IDLE cycle.

Optional Feature:
- Macro: RV_WB_ARBITER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every grant and increments each cycle in INSTR/DATA.
  - When count reaches TIMEOUT_CYCLES-1 with no ack: drop cyc/stb, pulse the granted requester's ack and o_bus_err together for 1 cycle, drive read data to 32'h0, go to IDLE.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter is built, o_bus_err is tied to 0, and the arbiter waits indefinitely.

Decomposition:
- Package rv_wb_arb_pkg: state enum (IDLE/INSTR/DATA), grant enum, and the constants WB_SEL_ALL=4'hF and TIMEOUT_CNT_BITS=16.
- One sub-module, rv_wb_timeout: clear/enable/expire counter, instantiated only under the macro.

Test Plan:
- Fetch alone: instr_req, addr=0x1234 (IADDR_SPACE_BITS=16, RESET_ADDR=0x8000_0000), slave acks after 2 waits → o_wb_adr=0x8000_2468, sel=F, we=0, o_instr_ack one cycle with data 0xDEADBEEF, cyc low next cycle.
- Collision: instr and data requests rise together; store addr=0x100, wdata=0xA5A5A5A5, sel=0x3 → DATA granted first with we=1, INSTR granted after the one idle cycle.
- Starvation: data_req held continuously with instr pending, DATA_STREAK_MAX=4 → exactly 4 data transfers, then 1 fetch, then data resumes.
- Reset mid-transfer: i_reset_n low while in DATA with no ack → cyc/stb/outputs 0 asynchronously, no ack; after release the FSM is in IDLE.
- Spurious i_wb_ack in IDLE → no requester ack, no state change.
- With macro, TIMEOUT_CYCLES=8, slave never acks → o_bus_err and o_data_ack pulse 8 cycles after cyc rises, rdata 0. Second run with ack on cycle 8 → normal ack, no error.
